// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port among NUM_REQ engines.
// Define ARB_TIMEOUT_EN to revoke grants held MAX_HOLD cycles without mem_opdone.
module mem_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*NUM_REQ-1:0]  req_op,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [31:0]           req_rdata,
    output logic [NUM_REQ-1:0]    req_opdone,
    output logic [1:0]            mem_operation,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_opdone,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  timeout
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;
    state_t state, state_n;
    logic [NUM_REQ-1:0] active, eligible, grant_n;
    logic [IW-1:0] gidx, gidx_n, last, last_n, win;
    logic granted;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("mem_port_arbiter: unsupported NUM_REQ/MAX_HOLD");
    end

    // Read (01) and write (11) share bit 0; 00 and reserved 10 do not.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) active[r] = req_op[2*r];
    end

`ifdef ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0] mask, mask_n, idle_op;
    logic [31:0] hold, hold_n;
    logic timeout_n;
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) idle_op[r] = req_op[2*r+:2] == 2'b00;
    end
    assign eligible = active & ~mask;
`else
    assign eligible = active;
    assign timeout  = 1'b0;
`endif

    // Scan downward so the candidate nearest after last overwrites the rest.
    always_comb begin
        win = last;
        for (int k = NUM_REQ; k >= 1; k--)
            if (eligible[(int'(last) + k) % NUM_REQ]) win = IW'((int'(last) + k) % NUM_REQ);
    end

    assign granted       = state == GRANTED;
    assign req_rdata     = mem_rdata;
    assign mem_operation = granted ? req_op[2*gidx+:2] : 2'b00;
    assign mem_addr      = granted ? req_addr[32*gidx+:32] : 32'd0;
    assign mem_wdata     = granted ? req_wdata[32*gidx+:32] : 32'd0;
    assign req_opdone    = (granted && mem_opdone) ? grant : '0;

    always_comb begin
        state_n = state;
        grant_n = grant;
        gidx_n  = gidx;
        last_n  = last;
`ifdef ARB_TIMEOUT_EN
        mask_n    = mask & ~idle_op;
        hold_n    = hold;
        timeout_n = 1'b0;
`endif
        case (state)
            IDLE: if (|eligible) begin
                state_n = GRANTED;
                grant_n = NUM_REQ'(1) << win;
                gidx_n  = win;
`ifdef ARB_TIMEOUT_EN
                hold_n  = 32'd0;
`endif
            end
            GRANTED: if (!active[gidx]) begin
                state_n = RELEASE;
                grant_n = '0;
                last_n  = gidx;
            end
`ifdef ARB_TIMEOUT_EN
            else if (!mem_opdone && hold == 32'(MAX_HOLD - 1)) begin
                state_n      = RELEASE;
                grant_n      = '0;
                last_n       = gidx;
                timeout_n    = 1'b1;
                mask_n[gidx] = 1'b1;
            end else begin
                hold_n = mem_opdone ? 32'd0 : hold + 32'd1;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            last  <= IW'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            mask    <= '0;
            hold    <= 32'd0;
            timeout <= 1'b0;
`endif
        end else begin
            state <= state_n;
            grant <= grant_n;
            gidx  <= gidx_n;
            last  <= last_n;
`ifdef ARB_TIMEOUT_EN
            mask    <= mask_n;
            hold    <= hold_n;
            timeout <= timeout_n;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_mem_port_arbiter;
    localparam int N    = 4;
    localparam int HOLD = 8;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [2*N-1:0] req_op;
    logic [32*N-1:0] req_addr, req_wdata;
    logic [31:0] req_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [N-1:0] req_opdone, grant;
    logic [1:0] mem_operation;
    logic mem_opdone, timeout;
    logic [1:0] op [N];
    logic [31:0] addr [N];
    logic [31:0] wd [N];
    int n_chk = 0;
    int n_fail = 0;

    mem_port_arbiter #(.NUM_REQ(N), .MAX_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdata(req_rdata), .req_opdone(req_opdone), .mem_operation(mem_operation),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_opdone(mem_opdone), .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_op[2*g+:2]     = op[g];
        assign req_addr[32*g+:32]  = addr[g];
        assign req_wdata[32*g+:32] = wd[g];
    end

    task automatic do_reset();
        reset = 1'b1;
        for (int r = 0; r < N; r++) begin
            op[r] = 2'b00; addr[r] = 32'd0; wd[r] = 32'd0;
        end
        mem_opdone = 1'b0;
        mem_rdata  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int r = 0; r < N; r++) begin
            op[r] = 2'b01; addr[r] = 32'h100 * r; wd[r] = r;
        end
        mem_opdone = 1'b1;
        mem_rdata  = 32'hA5A5_5A5A;
        repeat (3) @(negedge clk);
        n_chk++;
        if (grant !== '0 || timeout !== 1'b0 || req_opdone !== '0) begin
            n_fail++; $display("FAIL reset_state: got grant=%b timeout=%b opdone=%b want 0000/0/0000", grant, timeout, req_opdone);
        end
        n_chk++;
        if (mem_operation !== 2'b00 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || req_rdata !== 32'hA5A5_5A5A) begin
            n_fail++; $display("FAIL reset_mem: got op=%b addr=%h wdata=%h rdata=%h want 00/0/0/a5a55a5a", mem_operation, mem_addr, mem_wdata, req_rdata);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        op[1] = 2'b01; addr[1] = 32'h10; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_chk++;
        if (grant !== 4'b0010 || mem_operation !== 2'b01 || mem_addr !== 32'h10) begin
            n_fail++; $display("FAIL read_grant: got grant=%b op=%b addr=%h want 0010/01/10", grant, mem_operation, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (grant !== 4'b0010 || req_opdone !== '0) begin
            n_fail++; $display("FAIL read_wait: got grant=%b opdone=%b want 0010/0000", grant, req_opdone);
        end
        mem_opdone = 1'b1;
        #1;
        n_chk++;
        if (req_opdone !== 4'b0010 || req_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL read_done: got opdone=%b rdata=%h want 0010/deadbeef", req_opdone, req_rdata);
        end
        @(negedge clk);
        mem_opdone = 1'b0; op[1] = 2'b00;
        @(negedge clk);
        n_chk++;
        if (grant !== '0 || mem_operation !== 2'b00) begin
            n_fail++; $display("FAIL read_release: got grant=%b op=%b want 0000/00", grant, mem_operation);
        end
    endtask

    task automatic test_rr_order();
        int order [3] = '{0, 2, 3};
        logic [N-1:0] exp, g1;
        do_reset();
        for (int r = 0; r < N; r++) addr[r] = 32'h40 + r;
        op[0] = 2'b01; op[2] = 2'b01; op[3] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            exp = N'(1) << order[i];
            @(negedge clk);
            n_chk++;
            if (grant !== exp || mem_addr !== addr[order[i]]) begin
                n_fail++; $display("FAIL rr_grant %0d: got grant=%b addr=%h want %b/%h", i, grant, mem_addr, exp, addr[order[i]]);
            end
            mem_opdone = 1'b1;
            @(negedge clk);
            n_chk++;
            if (req_opdone !== exp) begin
                n_fail++; $display("FAIL rr_opdone %0d: got %b want %b", i, req_opdone, exp);
            end
            op[order[i]] = 2'b00; mem_opdone = 1'b0;
            @(negedge clk);
            g1 = grant;
            @(negedge clk);
            n_chk++;
            if (g1 !== '0 || grant !== '0) begin
                n_fail++; $display("FAIL rr_gap %0d: got %b,%b want 0000,0000", i, g1, grant);
            end
        end
    endtask

    task automatic test_burst_hold();
        logic [N-1:0] g1;
        do_reset();
        op[0] = 2'b01; op[1] = 2'b01; addr[1] = 32'h100;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            addr[0] = i; mem_opdone = 1'b1;
            #1;
            n_chk++;
            if (grant !== 4'b0001 || mem_addr !== i || req_opdone !== 4'b0001) begin
                n_fail++; $display("FAIL burst_word %0d: got grant=%b addr=%h opdone=%b want 0001/%h/0001", i, grant, mem_addr, req_opdone, i);
            end
            @(negedge clk);
        end
        mem_opdone = 1'b0; op[0] = 2'b00;
        @(negedge clk);
        g1 = grant;
        @(negedge clk);
        n_chk++;
        if (g1 !== '0 || grant !== '0) begin
            n_fail++; $display("FAIL burst_gap: got %b,%b want 0000,0000", g1, grant);
        end
        @(negedge clk);
        n_chk++;
        if (grant !== 4'b0010 || mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL burst_next: got grant=%b addr=%h want 0010/100", grant, mem_addr);
        end
    endtask

    task automatic test_write();
        do_reset();
        mem_opdone = 1'b1;
        #1;
        n_chk++;
        if (req_opdone !== '0 || mem_operation !== 2'b00 || grant !== '0) begin
            n_fail++; $display("FAIL idle_opdone: got opdone=%b op=%b grant=%b want 0000/00/0000", req_opdone, mem_operation, grant);
        end
        op[2] = 2'b11; addr[2] = 32'h20; wd[2] = 32'h1234;
        @(negedge clk);
        n_chk++;
        if (grant !== 4'b0100 || mem_operation !== 2'b11 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin
            n_fail++; $display("FAIL write_port: got grant=%b op=%b addr=%h wdata=%h want 0100/11/20/1234", grant, mem_operation, mem_addr, mem_wdata);
        end
        n_chk++;
        if (req_opdone !== 4'b0100) begin
            n_fail++; $display("FAIL write_opdone: got %b want 0100", req_opdone);
        end
        @(negedge clk);
        op[2] = 2'b00;
        @(negedge clk);
        n_chk++;
        if (req_opdone !== '0 || mem_wdata !== 32'd0 || mem_operation !== 2'b00) begin
            n_fail++; $display("FAIL write_release: got opdone=%b wdata=%h op=%b want 0000/0/00", req_opdone, mem_wdata, mem_operation);
        end
        mem_opdone = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        op[1] = 2'b01;
        @(negedge clk);
        op[1] = 2'b00;
        @(negedge clk);
        op[3] = 2'b11; addr[3] = 32'h30; wd[3] = 32'h3333;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (grant !== 4'b1000 || mem_operation !== 2'b11) begin
            n_fail++; $display("FAIL midwrite_grant: got grant=%b op=%b want 1000/11", grant, mem_operation);
        end
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (grant !== '0 || mem_operation !== 2'b00 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: got grant=%b op=%b addr=%h wdata=%h want all zero", grant, mem_operation, mem_addr, mem_wdata);
        end
        op[0] = 2'b01;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_winner: got %b want 0001", grant);
        end
    endtask

    task automatic test_timeout();
        int cnt, seen;
        do_reset();
        op[0] = 2'b01; op[1] = 2'b01;
`ifdef ARB_TIMEOUT_EN
        cnt = 0; seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(negedge clk);
            if (grant == 4'b0001) cnt++;
            if (timeout) seen = 1;
        end
        n_chk++;
        if (seen != 1 || cnt != HOLD || grant !== '0) begin
            n_fail++; $display("FAIL timeout_pulse: got seen=%0d cycles=%0d grant=%b want 1/%0d/0000", seen, cnt, grant, HOLD);
        end
        @(negedge clk);
        n_chk++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_width: got %b want 0", timeout);
        end
        @(negedge clk);
        n_chk++;
        if (grant !== 4'b0010) begin
            n_fail++; $display("FAIL timeout_next: got %b want 0010", grant);
        end
        op[1] = 2'b00; mem_opdone = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (grant == 4'b0001) cnt++;
        end
        n_chk++;
        if (cnt != 0) begin
            n_fail++; $display("FAIL timeout_mask: got %0d grant cycles want 0", cnt);
        end
        op[0] = 2'b00;
        @(negedge clk);
        op[0] = 2'b01;
        @(negedge clk);
        n_chk++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL timeout_unmask: got %b want 0001", grant);
        end
        mem_opdone = 1'b0;
`else
        cnt = 0; seen = 0;
        repeat (3 * HOLD) begin
            @(negedge clk);
            if (grant == 4'b0001) cnt++;
            if (timeout) seen = 1;
        end
        n_chk++;
        if (cnt != 3 * HOLD || seen != 0) begin
            n_fail++; $display("FAIL hold_forever: got cycles=%0d timeout=%0d want %0d/0", cnt, seen, 3 * HOLD);
        end
`endif
    endtask

    task automatic test_random();
        int owner, last, rel, left;
        int rem [N];
        logic [N-1:0] eg, ed;
        logic [1:0] eo;
        logic [31:0] ea, ew;
        do_reset();
        owner = -1; last = N - 1; rel = 0;
        for (int r = 0; r < N; r++) rem[r] = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            // Advance the model across the clock edge just taken, using the inputs it sampled.
            if (owner >= 0) begin
                if (!(op[owner] inside {2'b01, 2'b11})) begin
                    last = owner; owner = -1; rel = 1;
                end
            end else if (rel != 0) rel = 0;
            else for (int k = 1; k <= N && owner < 0; k++)
                if (op[(last + k) % N] inside {2'b01, 2'b11}) owner = (last + k) % N;
            eg = '0; eo = 2'b00; ea = 32'd0; ew = 32'd0;
            if (owner >= 0) begin
                eg[owner] = 1'b1; eo = op[owner]; ea = addr[owner]; ew = wd[owner];
            end
            ed = mem_opdone ? eg : '0;
            n_chk++;
            if ({grant, mem_operation, mem_addr, mem_wdata, req_opdone} !== {eg, eo, ea, ew, ed}) begin
                n_fail++;
                $display("FAIL random_port cycle %0d: got grant=%b op=%b addr=%h wdata=%h opdone=%b want grant=%b op=%b addr=%h wdata=%h opdone=%b",
                         c, grant, mem_operation, mem_addr, mem_wdata, req_opdone, eg, eo, ea, ew, ed);
            end
            n_chk++;
            if (req_rdata !== mem_rdata || timeout !== 1'b0) begin
                n_fail++; $display("FAIL random_misc cycle %0d: got rdata=%h timeout=%b want %h/0", c, req_rdata, timeout, mem_rdata);
            end
            for (int r = 0; r < N; r++) begin
                if (ed[r]) begin
                    rem[r]--;
                    op[r] = (rem[r] == 0) ? 2'b00 : ($urandom_range(0, 1) ? 2'b01 : 2'b11);
                    addr[r] = $urandom; wd[r] = $urandom;
                end else if (rem[r] == 0 && c < 1100 && $urandom_range(0, 7) == 0) begin
                    rem[r] = $urandom_range(1, 4);
                    op[r] = $urandom_range(0, 1) ? 2'b01 : 2'b11;
                    addr[r] = $urandom; wd[r] = $urandom;
                end else if (rem[r] == 0) op[r] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            end
`ifdef ARB_TIMEOUT_EN
            mem_opdone = 1'b1;
`else
            mem_opdone = ($urandom_range(0, 2) == 0);
`endif
            mem_rdata = $urandom;
        end
        left = 0;
        for (int r = 0; r < N; r++) left += rem[r];
        n_chk++;
        if (left != 0) begin
            n_fail++; $display("FAIL random_drain: got %0d ops outstanding want 0", left);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_order();
        test_burst_hold();
        test_write();
        test_async_reset();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesting engines (2..8).
REQ-002 Parameter: MAX_HOLD, default 256, timeout cycles without mem_opdone (used only under REQ-031).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req_op  in  2*NUM_REQ  per-requester mem_operation; 01 read, 11 write, 00 none, 10 reserved.
REQ-006 Port: req_addr  in  32*NUM_REQ  per-requester address, slice r at [32r+31:32r].
REQ-007 Port: req_wdata  in  32*NUM_REQ  per-requester write data.
REQ-008 Port: req_rdata  out  32  read data, broadcast to all requesters.
REQ-009 Port: req_opdone  out  NUM_REQ  per-requester completion strobe.
REQ-010 Port: mem_operation  out  2  shared memory command.
REQ-011 Port: mem_addr  out  32  shared memory address.
REQ-012 Port: mem_wdata  out  32  shared memory write data.
REQ-013 Port: mem_rdata  in  32  shared memory read data.
REQ-014 Port: mem_opdone  in  1  shared memory completion strobe.
REQ-015 Port: grant  out  NUM_REQ  one-hot registered grant; all-zero when idle.
REQ-016 Port: timeout  out  1  one-cycle pulse on forced grant revocation.

Function
REQ-017 Active request: req_op slice equal to 01 or 11; 10 and 00 are inactive.
REQ-018 FSM states: IDLE, GRANTED, RELEASE.
REQ-019 IDLE: if any active request, register one-hot grant to winner and go to GRANTED next cycle; else stay.
REQ-020 Winner: round-robin, searching from index (last_winner+1) mod NUM_REQ upward with wrap; last_winner resets to NUM_REQ-1 so requester 0 wins first.
REQ-021 GRANTED: mem_operation/mem_addr/mem_wdata combinationally equal granted requester's slices; req_opdone[g] = mem_opdone; other req_opdone bits 0.
REQ-022 Outside GRANTED: mem_operation = 00, mem_addr = 0, mem_wdata = 0, all req_opdone = 0.
REQ-023 req_rdata = mem_rdata in all states.
REQ-024 Grant held across consecutive operations (multi-word bursts, address changes) while granted req_op remains active.
REQ-025 GRANTED -> RELEASE when granted req_op becomes inactive; grant cleared, last_winner updated to granted index.
REQ-026 RELEASE -> IDLE unconditionally after one cycle; guarantees one dead cycle between owners.
REQ-027 mem_opdone outside GRANTED ignored.
REQ-028 Request asserted by non-granted requester is held pending; no loss, no opdone until granted.
REQ-029 Grant latency from IDLE: grant and mem_* valid on the cycle after request sampled.

Reset
REQ-030 On reset assertion (any time, including mid-transfer): state IDLE, grant 0, last_winner NUM_REQ-1, timeout 0, hold counter 0; mem_* outputs 0 immediately.

Configuration
REQ-031 Macro ARB_TIMEOUT_EN defined: 32-bit hold counter clears on entry to GRANTED and on each mem_opdone, increments each GRANTED cycle; at MAX_HOLD go to RELEASE, pulse timeout one cycle, mask that requester from arbitration until its req_op reads 00 for at least one cycle.
REQ-032 Macro ARB_TIMEOUT_EN undefined: no counter or mask logic; timeout tied 0; grant held indefinitely.

Verification
REQ-033 Reset, requester 1 read addr 0x10, mem_opdone after 3 cycles, rdata 0xDEADBEEF -> grant=0010 one cycle after request, req_opdone[1] pulses, req_rdata=0xDEADBEEF.
REQ-034 Requesters 0,2,3 request simultaneously, each releasing after one op -> grant order 0,2,3 with one RELEASE cycle between owners.
REQ-035 Requester 0 holds read for addrs 0..4 with five opdones while requester 1 waits -> grant stays 0001 throughout; requester 1 granted after release.
REQ-036 Requester 2 write data 0x1234 to 0x20 -> mem_operation=11, mem_addr=0x20, mem_wdata=0x1234 while granted; opdone to requesters 0,1,3 never asserted.
REQ-037 Reset asserted mid-write -> mem_operation 0 and grant 0 without waiting for clock edge; after release requester 0 wins first.
REQ-038 ARB_TIMEOUT_EN, MAX_HOLD=8, granted requester with no mem_opdone -> timeout pulse after 8 GRANTED cycles, next requester granted, stalled requester excluded until req_op=00.
